// File: rtl/noc_pkg.sv
// Shared definitions for the NoC flit injector: flit field layout,
// credit-return layout, counter sizing and the injector FSM states.
package noc_pkg;

  // Default widths of the generated mesh.
  localparam int DEF_DATA_W       = 64;
  localparam int DEF_DEST_W       = 4;
  localparam int DEF_VC_W         = 1;
  localparam int DEF_LEN_W        = 4;
  localparam int DEF_CREDIT_DEPTH = 4;

  // Flit layout, LSB first: data | vc | dest | tail | valid.
  function automatic int flit_w(input int data_w, input int dest_w, input int vc_w);
    return 2 + dest_w + vc_w + data_w;
  endfunction

  function automatic int flit_vc_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int flit_dest_lsb(input int data_w, input int vc_w);
    return data_w + vc_w;
  endfunction

  function automatic int flit_tail_bit(input int data_w, input int dest_w, input int vc_w);
    return data_w + vc_w + dest_w;
  endfunction

  function automatic int flit_valid_bit(input int data_w, input int dest_w, input int vc_w);
    return data_w + vc_w + dest_w + 1;
  endfunction

  // Credit return layout: {valid, vc}, vc in the low bits.
  function automatic int credit_w(input int vc_w);
    return 1 + vc_w;
  endfunction

  function automatic int credit_valid_bit(input int vc_w);
    return vc_w;
  endfunction

  // Counter must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_e;

endpackage

// File: rtl/noc_flit_injector_if.sv
// Command, flit and credit-return signals between a traffic driver and the
// flit injector. The injector takes the slave side.
interface noc_flit_injector_if #(
  parameter int DATA_W = 64,
  parameter int DEST_W = 4,
  parameter int VC_W   = 1,
  parameter int LEN_W  = 4
);
  import noc_pkg::*;

  localparam int FLIT_W = flit_w(DATA_W, DEST_W, VC_W);
  localparam int CR_W   = credit_w(VC_W);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DEST_W-1:0] cmd_dest;
  logic [VC_W-1:0]   cmd_vc;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_seed;
  logic [FLIT_W-1:0] flit_out;
  logic [CR_W-1:0]   credit_in;

  modport master (
    output cmd_valid, cmd_dest, cmd_vc, cmd_len, cmd_seed, credit_in,
    input  cmd_ready, flit_out
  );

  modport slave (
    input  cmd_valid, cmd_dest, cmd_vc, cmd_len, cmd_seed, credit_in,
    output cmd_ready, flit_out
  );

endinterface

// File: rtl/noc_vc_credit_counter.sv
// Per-VC credit counter: loads DEPTH on reset, -1 per send, +1 per return.
// A return that would exceed DEPTH saturates and sets a sticky error flag.
module noc_vc_credit_counter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = noc_pkg::cnt_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Next count: simultaneous send and return cancel out.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (inc && !dec) begin
      if (count_q == MAX_CNT) err_d = 1'b1;
      else                    count_d = count_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
    end
  end

  // Counter and error flag registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_q <= MAX_CNT;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: rtl/noc_flit_injector.sv
// Credit-aware flit source for one mesh send port. Accepts packet commands
// and emits one registered flit per cycle while the packet's VC has credit.
// Build option NOC_INJ_TIMESTAMP_EN: stamps a free-running 32-bit cycle
// count into the top 32 data bits of each head flit (needs DATA_W >= 32).
//
// state   | meaning
// IDLE    | ready for a command, no flits emitted
// SEND    | serialising the latched packet, stalls while VC has no credit
module noc_flit_injector
  import noc_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEST_W       = DEF_DEST_W,
  parameter int VC_W         = DEF_VC_W,
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
  parameter int LEN_W        = DEF_LEN_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  noc_flit_injector_if.slave   inj,
  output logic                 busy,
  output logic [15:0]          pkts_sent,
  output logic                 credit_err
);

  localparam int NUM_VCS  = 2 ** VC_W;
  localparam int FLIT_W   = flit_w(DATA_W, DEST_W, VC_W);
  localparam int CNT_W    = cnt_w(CREDIT_DEPTH);
  localparam int CR_VALID = credit_valid_bit(VC_W);

  inj_state_e        state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic [LEN_W-1:0]  last_q, last_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic [15:0]       pkts_q, pkts_d;

  logic [DATA_W-1:0] data_c;
  logic              send;
  logic              can_send;
  logic              ret_valid;
  logic [VC_W-1:0]   ret_vc;
  logic [NUM_VCS-1:0] dec_vc, inc_vc, err_vc;
  logic [CNT_W-1:0]  cnt_vc [NUM_VCS];

  assign ret_valid = inj.credit_in[CR_VALID];
  assign ret_vc    = inj.credit_in[VC_W-1:0];

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign dec_vc[v] = send && (vc_q == VC_W'(v));
    assign inc_vc[v] = ret_valid && (ret_vc == VC_W'(v));

    noc_vc_credit_counter #(
      .DEPTH (CREDIT_DEPTH),
      .CNT_W (CNT_W)
    ) u_credit (
      .CLK   (CLK),
      .RST_N (RST_N),
      .dec   (dec_vc[v]),
      .inc   (inc_vc[v]),
      .count (cnt_vc[v]),
      .err   (err_vc[v])
    );
  end

  // Decision uses the registered count, so a return is usable next cycle.
  assign can_send = (cnt_vc[vc_q] != '0);

`ifdef NOC_INJ_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;

  // Free-running cycle count for head-flit timestamps.
  always_comb ts_d = ts_q + 32'd1;

  // Timestamp register, zero in the first cycle after reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) ts_q <= '0;
    else        ts_q <= ts_d;
  end
`endif

  // Payload: seed plus flit index, head optionally stamped in the top bits.
  always_comb begin
    data_c = seed_q + DATA_W'(idx_q);
`ifdef NOC_INJ_TIMESTAMP_EN
    if (idx_q == '0) data_c[DATA_W-1 -: 32] = ts_q;
`endif
  end

  // FSM next state, packet latch and flit generation.
  always_comb begin
    state_d       = state_q;
    dest_d        = dest_q;
    vc_d          = vc_q;
    last_d        = last_q;
    idx_d         = idx_q;
    seed_d        = seed_q;
    flit_d        = '0;
    pkts_d        = pkts_q;
    send          = 1'b0;
    busy          = 1'b0;
    inj.cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        inj.cmd_ready = 1'b1;
        if (inj.cmd_valid) begin
          dest_d  = inj.cmd_dest;
          vc_d    = inj.cmd_vc;
          seed_d  = inj.cmd_seed;
          last_d  = (inj.cmd_len == '0) ? '0 : inj.cmd_len - LEN_W'(1);
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        busy = 1'b1;
        if (can_send) begin
          send   = 1'b1;
          flit_d = {1'b1, (idx_q == last_q), dest_q, vc_q, data_c};
          if (idx_q == last_q) begin
            pkts_d  = pkts_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, packet context and output registers; reset aborts any packet.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      vc_q    <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      seed_q  <= '0;
      flit_q  <= '0;
      pkts_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      vc_q    <= vc_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      flit_q  <= flit_d;
      pkts_q  <= pkts_d;
    end
  end

  assign inj.flit_out = flit_q;
  assign pkts_sent    = pkts_q;
  assign credit_err   = |err_vc;

endmodule
